// File: rtl/ipml_prefetch_fifo_sync_lvl.sv
// Single-clock first-word-fall-through FIFO: simple dual-port RAM with 1-cycle read
// latency feeding a 2-entry prefetch stage, with water level, thresholds and strobes.
module ipml_prefetch_fifo_sync_lvl #(
   parameter int c_DEPTH_WIDTH = 4,
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_AF_LEVEL    = (1 << c_DEPTH_WIDTH) - 2,
   parameter int c_AE_LEVEL    = 1,
   parameter int c_BYPASS      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   input  logic                     wr_en,
   output logic                     wr_vld,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   input  logic                     rd_en,
   output logic                     rd_vld,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int CAP = 1 << c_DEPTH_WIDTH;
   localparam int LW  = c_DEPTH_WIDTH + 1;
   localparam int PW  = c_DEPTH_WIDTH;
   localparam logic [LW-1:0] CAP_L = LW'(CAP);

   logic [c_DATA_WIDTH-1:0]  mem [CAP];
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [LW-1:0]            ram_cnt;
   logic                     inflight;
   logic [c_DATA_WIDTH-1:0]  ram_q;
   logic [1:0]               stg_cnt;
   logic [c_DATA_WIDTH-1:0]  stg0;
   logic [c_DATA_WIDTH-1:0]  stg1;
   logic [c_DATA_WIDTH-1:0]  s0_n;
   logic [c_DATA_WIDTH-1:0]  s1_n;
   logic [1:0]               stg_after;
   logic                     clr;
   logic                     push;
   logic                     pop;
   logic                     issue;
   logic                     byp;
   logic                     ram_wr;

   assign clr          = rst | flush;
   assign wr_vld       = (water_level != CAP_L);
   assign rd_vld       = (stg_cnt != 2'd0);
   assign rd_data      = stg0;
   assign push         = wr_en & wr_vld & ~clr;
   assign pop          = rd_en & rd_vld & ~clr;
   assign almost_full  = (int'(water_level) >= c_AF_LEVEL);
   assign almost_empty = (int'(water_level) <= c_AE_LEVEL);

   // Slots left after this cycle's pop, minus the read already in flight, gate a new read.
   assign stg_after = stg_cnt - {1'b0, pop};
   assign issue     = (ram_cnt != '0) && ((stg_after + {1'b0, inflight}) < 2'd2) && !clr;

   // Bypass masquerades as a RAM read issued this cycle, so it lands one edge later.
   assign byp    = (c_BYPASS != 0) && push && (ram_cnt == '0) && !inflight && (stg_after < 2'd2);
   assign ram_wr = push & ~byp;

   // Next prefetch contents: shift on pop, then drop the returning word behind the survivors.
   always_comb begin
      s0_n = stg0;
      s1_n = stg1;
      if (pop) begin
         s0_n = stg1;
      end
      if (inflight) begin
         if (stg_after == 2'd0) begin
            s0_n = ram_q;
         end else begin
            s1_n = ram_q;
         end
      end
   end

   // Storage array and its read register carry no reset.
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         mem[wr_ptr] <= wr_data;
      end
      if (issue) begin
         ram_q <= mem[rd_ptr];
      end else if (byp) begin
         ram_q <= wr_data;
      end
   end

   // Pointers, counts, prefetch stage and strobes; flush behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         inflight    <= 1'b0;
         stg_cnt     <= 2'd0;
         stg0        <= '0;
         stg1        <= '0;
         water_level <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (ram_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         ram_cnt     <= ram_cnt + LW'(ram_wr) - LW'(issue);
         inflight    <= issue | byp;
         stg_cnt     <= stg_after + {1'b0, inflight};
         stg0        <= s0_n;
         stg1        <= s1_n;
         water_level <= water_level + LW'(push) - LW'(pop);
         overflow    <= wr_en & ~wr_vld;
         underflow   <= rd_en & ~rd_vld;
      end
   end

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_lvl.sv
// Bench for the prefetch FIFO: queue-based reference model, scoreboard monitor,
// directed boundary tests and a randomized traffic phase.
module tb_ipml_prefetch_fifo_sync_lvl;

   localparam int CAP = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
   logic [7:0] rd_data;
   logic [4:0] water_level;

   logic       b_wr_en = 1'b0;
   logic [7:0] b_wr_data = 8'h00;
   logic       b_rd_en = 1'b0;
   logic       b_wr_vld, b_rd_vld, b_af, b_ae, b_ovf, b_unf;
   logic [7:0] b_rd_data;
   logic [4:0] b_level;

   int         total = 0;
   int         bad = 0;
   int         mlevel = 0;
   logic       exp_ovf = 1'b0;
   logic       exp_unf = 1'b0;
   logic       started = 1'b0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   ipml_prefetch_fifo_sync_lvl #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_BYPASS(0)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en), .wr_vld(wr_vld),
      .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld), .water_level(water_level),
      .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
      .underflow(underflow));

   ipml_prefetch_fifo_sync_lvl #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .flush(flush), .wr_data(b_wr_data), .wr_en(b_wr_en), .wr_vld(b_wr_vld),
      .rd_data(b_rd_data), .rd_en(b_rd_en), .rd_vld(b_rd_vld), .water_level(b_level),
      .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf));

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model is advanced from the FIFO rules after the edge.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
      logic clr, mpush, mpop, vld_before;
      wr_en = w;
      wr_data = d;
      rd_en = r;
      flush = f;
      clr = rst | f;
      vld_before = rd_vld;
      mpush = w && (mlevel != CAP) && !clr;
      mpop = r && vld_before && !clr;
      @(posedge clk);
      #1;
      if (clr) begin
         mlevel = 0;
         sb.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         exp_ovf = w && (mlevel == CAP);
         exp_unf = r && !vld_before;
         if (mpush) sb.push_back(d);
         mlevel = mlevel + int'(mpush) - int'(mpop);
      end
   endtask

   // Monitor: status against the model level, popped data against the scoreboard head.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("level", int'(water_level), mlevel);
         checkOutput("wr_vld", int'(wr_vld), int'(mlevel != CAP));
         checkOutput("almost_full", int'(almost_full), int'(mlevel >= CAP - 2));
         checkOutput("almost_empty", int'(almost_empty), int'(mlevel <= 1));
         checkOutput("overflow", int'(overflow), int'(exp_ovf));
         checkOutput("underflow", int'(underflow), int'(exp_unf));
         if (mlevel == 0) checkOutput("rd_vld_empty", int'(rd_vld), 0);
         if (rd_vld && rd_en && !rst && !flush) begin
            if (sb.size() == 0) begin
               checkOutput("pop_unexpected", 1, 0);
            end else begin
               checkOutput("rd_data", int'(rd_data), int'(sb.pop_front()));
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (mlevel != 0 && n < 64) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         n++;
      end
      checkOutput("drain_done", mlevel, 0);
   endtask

   initial begin
      int pw, pr, n;
      logic [7:0] d;

      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      started = 1'b1;
      checkOutput("rst_level", int'(water_level), 0);
      checkOutput("rst_wr_vld", int'(wr_vld), 1);
      checkOutput("rst_rd_vld", int'(rd_vld), 0);
      checkOutput("rst_ae", int'(almost_empty), 1);
      checkOutput("rst_af", int'(almost_full), 0);
      checkOutput("rst_rd_data", int'(rd_data), 0);
      checkOutput("rst_byp_level", int'(b_level), 0);
      checkOutput("rst_byp_rd_vld", int'(b_rd_vld), 0);

      // Fill to capacity, then one refused push
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
         checkOutput("fill_af", int'(almost_full), int'(i + 1 >= 14));
      end
      checkOutput("full_wr_vld", int'(wr_vld), 0);
      checkOutput("full_level", int'(water_level), 16);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      checkOutput("ovf_pulse", int'(overflow), 1);
      checkOutput("ovf_level", int'(water_level), 16);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ovf_clear", int'(overflow), 0);
      drain();

      // Pop at empty
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("unf_pulse", int'(underflow), 1);
      checkOutput("unf_level", int'(water_level), 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("unf_clear", int'(underflow), 0);

      // Latency of a single word into empty FIFOs, with and without bypass
      b_wr_en = 1'b1;
      b_wr_data = 8'hA5;
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      b_wr_en = 1'b0;
      checkOutput("lat_n_main", int'(rd_vld), 0);
      checkOutput("lat_n_byp", int'(b_rd_vld), 0);
      checkOutput("lat_byp_level", int'(b_level), 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("lat_n1_main", int'(rd_vld), 0);
      checkOutput("lat_n1_byp", int'(b_rd_vld), 1);
      checkOutput("lat_n1_byp_data", int'(b_rd_data), 8'hA5);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("lat_n2_main", int'(rd_vld), 1);
      checkOutput("lat_n2_main_data", int'(rd_data), 8'hA5);
      b_rd_en = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      b_rd_en = 1'b0;
      checkOutput("lat_byp_drained", int'(b_level), 0);

      // Streaming at level 3
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
         checkOutput("stream_vld", int'(rd_vld), 1);
      end

      // Hold: no pops while pushes continue
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
         checkOutput("hold_vld", int'(rd_vld), 1);
         checkOutput("hold_data", int'(rd_data), int'(sb[0]));
      end
      drain();

      // Flush at level 9 with a RAM read in flight
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pre_flush_level", int'(water_level), 9);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
      checkOutput("flush_level", int'(water_level), 0);
      checkOutput("flush_rd_vld", int'(rd_vld), 0);
      checkOutput("flush_wr_vld", int'(wr_vld), 1);
      applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
      n = 0;
      while (!rd_vld && n < 8) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         n++;
      end
      checkOutput("post_flush_vld", int'(rd_vld), 1);
      checkOutput("post_flush_data", int'(rd_data), 8'h3C);
      drain();

      // Randomized traffic with shifting push/pop bias and rare flushes
      for (int ph = 0; ph < 12; ph++) begin
         pw = $urandom_range(10, 95);
         pr = $urandom_range(10, 95);
         for (int i = 0; i < 200; i++) begin
            d = 8'($urandom);
            applyStimulus($urandom_range(0, 99) < pw, d, $urandom_range(0, 99) < pr,
                          $urandom_range(0, 127) == 0);
         end
      end
      drain();

      started = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
